enc_packer: RTL
===============

// Module: enc_packer
// PURPOSE
//  Downstream of the output formatter. Consumes its variable-fill beats: for_request valid
//  symbols in lanes [0..for_request-1]. Repacks them into full SYM_NUM-symbol output beats
//  with a valid/ready handshake. At codeword end it flushes one final partial beat.
//  Gives the encoder's sink a dense symbol stream regardless of message/parity phase boundaries.
// PARAMETERS
//  SYM_NUM    ENC_SYM_NUM  symbols per beat, in and out
//  SYM_WIDTH  EGF_ORDER    bits per symbol (GF order)
// PORTS
//  clk          in   1                        clock
//  rst          in   1                        reset; synchronous, active-high, single clock domain
//  for_valid    in   1                        input beat valid
//  for_ready    out  1                        input beat accepted when for_valid&&for_ready
//  for_request  in   $clog2(SYM_NUM+1)        number of valid symbols in for_data, 0..SYM_NUM
//  for_data     in   SYM_NUM*SYM_WIDTH        symbols; lane 0 is oldest; lanes >=for_request ignored
//  for_last     in   1                        beat closes the codeword
//  out_valid    out  1                        output beat valid
//  out_ready    in   1                        sink accepts when out_valid&&out_ready
//  out_data     out  SYM_NUM*SYM_WIDTH        packed symbols; lane 0 oldest; lanes >=out_count are 0
//  out_count    out  $clog2(SYM_NUM+1)        valid symbols in out_data
//  out_last     out  1                        final beat of codeword
// BEHAVIOUR
//  State
//   - res_data: 2*SYM_NUM symbols.
//   - res_count: 0..2*SYM_NUM, width $clog2(2*SYM_NUM+1).
//   - flush: 1 bit.
//  Reset (rst high at posedge)
//   - res_data=0, res_count=0, flush=0.
//   - for_ready and out_valid are forced 0 while rst is high.
//  Output beat
//   - out_data = res_data[0..SYM_NUM-1] with lanes >= out_count masked to 0.
//   - out_count = min(res_count, SYM_NUM).
//   - out_valid = (res_count >= SYM_NUM) || flush.
//   - out_last = flush && (res_count <= SYM_NUM).
//  Input ready (combinational from out_ready; no combinational path from for_valid)
//   - out_fire = out_valid && out_ready.
//   - rem = res_count - (out_fire ? out_count : 0).
//   - for_ready = !flush && (rem <= SYM_NUM).
//  Update per cycle
//   - On out_fire, residue shifts down by out_count.
//   - On in_fire, for_data[0..for_request-1] is written at lane rem.
//   - res_count' = rem + (in_fire ? for_request : 0).
//   - Simultaneous in/out fire is legal and gives full throughput: 1 beat/cycle when for_request=SYM_NUM.
//  Flush
//   - in_fire with for_last sets flush.
//   - out_fire with out_last clears flush.
//   - While flush=1, no new input is accepted; beats drain, the last one carries out_last.
//   - flush with res_count=0 emits one beat with out_count=0, out_last=1.
//  Latency: a symbol accepted in cycle t appears on out_data no earlier than cycle t+1.
//  Stability: while out_valid && !out_ready, out_data/out_count/out_last hold.
//   Appends only land at lanes >= SYM_NUM in this case.
//  for_request=0 without for_last: accepted, no state change.
//  for_request > SYM_NUM: illegal; bench assertion fires; RTL behaviour unspecified.
//  rst mid-codeword discards residue and flush; the next beat starts a new codeword.
// STRUCTURE
//  - encoder.vh already supplies ENC_SYM_NUM and EGF_ORDER; no new typedefs needed.
//  - Add constant ENC_RES_NUM = 2*ENC_SYM_NUM to encoder.vh.
//  - One combinational sub-module, enc_packer_merge:
//     inputs res_data, out shift amount, rem, for_data, for_request;
//     output next res_data.
//  - Top level keeps counters, flush, handshake.
// TESTING (SYM_NUM=4, SYM_WIDTH=8, symbols s0,s1,... = 8'h01,8'h02,...)
//  1. Requests 3,3,2 (last on 3rd), out_ready=1 ->
//     beat {s0..s3} cnt4 last0, then {s4..s7} cnt4 last1; for_ready=0 the cycle after the last input.
//  2. Requests 4,4,4,4 back-to-back, out_ready=1 ->
//     for_ready stays 1; one out beat per cycle from cycle 2; order s0..s15.
//  3. Requests 4,4,4 with out_ready=0 ->
//     first two accepted (res_count=8), third stalls; out_data={s0..s3} holds.
//     Raise out_ready -> s0..s11 in order.
//  4. Request 2 with last ->
//     single beat cnt2, data {s0,s1,0,0}, last1.
//     Then request 0 with last on empty residue -> beat cnt0, data 0, last1.
//  5. Request 3, then request 0 without last, then request 1 with last -> beat {s0..s3} cnt4 last1.
//  6. Requests 4,3 then rst high 1 cycle mid-stream ->
//     out_valid=0 and for_ready=0 during rst; res_count=0 after rst.
//     Next request 1 with last -> beat cnt1, data {s(new),0,0,0}, last1.

Source files
------------

// File: rtl/enc_packer_pkg.sv
// -----------------------------------------------------------------------------
// enc_packer_pkg
//   Shared constants for the encoder output packer.
//   ENC_SYM_NUM : symbols per beat (input and output)
//   EGF_ORDER   : bits per symbol (GF order)
//   ENC_RES_NUM : residue depth in symbols (two beats)
// -----------------------------------------------------------------------------
package enc_packer_pkg;

  localparam int ENC_SYM_NUM = 4;
  localparam int EGF_ORDER   = 8;
  localparam int ENC_RES_NUM = 2 * ENC_SYM_NUM;

endpackage : enc_packer_pkg

// File: rtl/enc_packer_merge.sv
// -----------------------------------------------------------------------------
// enc_packer_merge
//   Combinational next-residue builder. Shifts the residue down by the number
//   of symbols leaving on the output beat, then overlays the incoming symbols
//   starting at lane rem_i.
// Ports
//   res_data_i  : current residue, RES_NUM symbols, lane 0 oldest
//   shift_i     : symbols leaving this cycle (0 when no output fire)
//   rem_i       : residue count after the shift; first free lane
//   for_data_i  : incoming beat, SYM_NUM symbols, lane 0 oldest
//   wr_count_i  : symbols to append (0 when no input fire)
//   res_data_o  : next residue
// -----------------------------------------------------------------------------
module enc_packer_merge
  import enc_packer_pkg::*;
#(
  parameter int SYM_NUM   = ENC_SYM_NUM,
  parameter int SYM_WIDTH = EGF_ORDER
) (
  input  logic [2*SYM_NUM*SYM_WIDTH-1:0]    res_data_i,
  input  logic [$clog2(SYM_NUM+1)-1:0]      shift_i,
  input  logic [$clog2(2*SYM_NUM+1)-1:0]    rem_i,
  input  logic [SYM_NUM*SYM_WIDTH-1:0]      for_data_i,
  input  logic [$clog2(SYM_NUM+1)-1:0]      wr_count_i,
  output logic [2*SYM_NUM*SYM_WIDTH-1:0]    res_data_o
);

  localparam int RES_NUM = 2 * SYM_NUM;

  logic [SYM_WIDTH-1:0] sym;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    res_data_o = '0;
    sym        = '0;
    for (int i = 0; i < RES_NUM; i++) begin
      sym = '0;
      // Shift-down: vacated top lanes fill with zero, which keeps every lane
      // at or above the residue count cleared.
      if (i + int'(shift_i) < RES_NUM) begin
        sym = res_data_i[(i + int'(shift_i))*SYM_WIDTH +: SYM_WIDTH];
      end
      // rem_i <= SYM_NUM and wr_count_i <= SYM_NUM, so the append window
      // always fits inside the residue.
      if ((i >= int'(rem_i)) && (i < int'(rem_i) + int'(wr_count_i))) begin
        sym = for_data_i[(i - int'(rem_i))*SYM_WIDTH +: SYM_WIDTH];
      end
      res_data_o[i*SYM_WIDTH +: SYM_WIDTH] = sym;
    end
  end

endmodule : enc_packer_merge

// File: rtl/enc_packer.sv
// -----------------------------------------------------------------------------
// enc_packer
//   Repacks variable-fill beats from the output formatter into dense
//   SYM_NUM-symbol beats. A beat flagged for_last closes the codeword: input
//   is blocked until the residue drains, and the final (possibly partial or
//   empty) beat carries out_last.
// Ports
//   clk, rst     : clock; synchronous active-high reset
//   for_valid    : input beat valid
//   for_ready    : input beat accepted when for_valid && for_ready
//   for_request  : valid symbols in for_data lanes [0..for_request-1]
//   for_data     : input symbols, lane 0 oldest
//   for_last     : input beat closes the codeword
//   out_valid    : output beat valid
//   out_ready    : sink accepts when out_valid && out_ready
//   out_data     : packed symbols, lane 0 oldest, lanes >= out_count zero
//   out_count    : valid symbols in out_data
//   out_last     : final beat of the codeword
// -----------------------------------------------------------------------------
module enc_packer
  import enc_packer_pkg::*;
#(
  parameter int SYM_NUM   = ENC_SYM_NUM,
  parameter int SYM_WIDTH = EGF_ORDER
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           for_valid,
  output logic                           for_ready,
  input  logic [$clog2(SYM_NUM+1)-1:0]   for_request,
  input  logic [SYM_NUM*SYM_WIDTH-1:0]   for_data,
  input  logic                           for_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SYM_NUM*SYM_WIDTH-1:0]   out_data,
  output logic [$clog2(SYM_NUM+1)-1:0]   out_count,
  output logic                           out_last
);

  localparam int RES_NUM = 2 * SYM_NUM;
  localparam int CW      = $clog2(SYM_NUM + 1);
  localparam int RW      = $clog2(RES_NUM + 1);

  logic [RES_NUM*SYM_WIDTH-1:0] res_data_q, res_data_d;
  logic [RW-1:0]                res_count_q, res_count_d;
  logic                         flush_q, flush_d;

  logic          out_fire, in_fire;
  logic [RW-1:0] rem;
  logic [CW-1:0] shift, wr_count;

  // Output beat straight from the residue head.
  assign out_count = (res_count_q >= RW'(SYM_NUM)) ? CW'(SYM_NUM) : res_count_q[CW-1:0];
  assign out_valid = !rst && ((res_count_q >= RW'(SYM_NUM)) || flush_q);
  assign out_last  = flush_q && (res_count_q <= RW'(SYM_NUM));

  always_comb begin
    out_data = '0;
    for (int i = 0; i < SYM_NUM; i++) begin
      if (i < int'(out_count)) begin
        out_data[i*SYM_WIDTH +: SYM_WIDTH] = res_data_q[i*SYM_WIDTH +: SYM_WIDTH];
      end
    end
  end

  // Ready looks at what remains after this cycle's output, so a full residue
  // beat can leave while the next one arrives. No path from for_valid.
  assign out_fire  = out_valid && out_ready;
  assign shift     = out_fire ? out_count : '0;
  assign rem       = res_count_q - RW'(shift);
  assign for_ready = !rst && !flush_q && (rem <= RW'(SYM_NUM));
  assign in_fire   = for_valid && for_ready;
  assign wr_count  = in_fire ? for_request : '0;

  assign res_count_d = rem + RW'(wr_count);

  // in_fire needs !flush and out_last needs flush, so the two never collide.
  always_comb begin
    flush_d = flush_q;
    if (in_fire && for_last) begin
      flush_d = 1'b1;
    end else if (out_fire && out_last) begin
      flush_d = 1'b0;
    end
  end

  enc_packer_merge #(
    .SYM_NUM   (SYM_NUM),
    .SYM_WIDTH (SYM_WIDTH)
  ) u_merge (
    .res_data_i (res_data_q),
    .shift_i    (shift),
    .rem_i      (rem),
    .for_data_i (for_data),
    .wr_count_i (wr_count),
    .res_data_o (res_data_d)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  // NOTE: the residue is cleared on reset on purpose: the merge relies on
  // lanes above res_count being zero, and a mid-codeword reset must discard
  // stale symbols.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_q  <= '0;
      res_count_q <= '0;
      flush_q     <= 1'b0;
    end else begin
      res_data_q  <= res_data_d;
      res_count_q <= res_count_d;
      flush_q     <= flush_d;
    end
  end

endmodule : enc_packer
